// File: rtl/bloom_lookup_sched.sv
// Round-robin scheduler for the shared Bloom-filter lookup engine.
// Also owns the BRAM write port for rule programming and table clear.
module bloom_lookup_sched #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*104-1:0]   req_tuple,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  input  logic                  eng_ready,
  output logic                  eng_start,
  output logic [103:0]          eng_tuple,
  input  logic                  eng_res_valid,
  input  logic                  eng_res,
  output logic                  eng_res_ack,
  input  logic                  cfg_valid,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  input  logic                  clear_start,
  output logic                  clear_done,
  output logic                  bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_din,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RES,
    CLEAR
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     win;
  logic [PW-1:0]     win_nxt;
  logic              win_ok;
  logic [103:0]      sel;
  logic [103:0]      tuple_q;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] clr_addr;
  logic              clear_pend;

  logic is_idle;
  logic do_clr;
  logic do_cfg;
  logic do_grant;
  logic res_now;
  logic tmo_now;
  logic clr_last;

  // cyclic search for the first valid requester at or after rr_ptr
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_ok && req_valid[i] && PW'(i) >= rr_ptr) begin
        win_ok = 1'b1;
        win    = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_ok && req_valid[i]) begin
        win_ok = 1'b1;
        win    = PW'(i);
      end
    end
  end

  // tuple mux for the winner and the pointer that follows it
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) sel = req_tuple[104*i +: 104];
    end
    win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // action decode; management traffic outranks lookups in IDLE
  always_comb begin
    is_idle  = (state == IDLE);
    do_clr   = is_idle && clear_pend;
    do_cfg   = is_idle && !clear_pend && cfg_valid;
    do_grant = is_idle && !clear_pend && !cfg_valid
               && eng_ready && win_ok;
    res_now  = (state == WAIT_RES) && eng_res_valid;
    tmo_now  = (state == WAIT_RES) && !eng_res_valid
               && (timer == TW'(TIMEOUT - 1));
    clr_last = (state == CLEAR) && (clr_addr == '1);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (do_clr)        state_n = CLEAR;
        else if (do_grant) state_n = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_now || tmo_now) state_n = IDLE;
      end
      CLEAR: begin
        if (clr_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // strobes and BRAM port, all combinational from state and inputs
  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_hit     = 1'b0;
    rsp_err     = 1'b0;
    eng_start   = 1'b0;
    eng_tuple   = tuple_q;
    eng_res_ack = 1'b0;
    cfg_ready   = 1'b0;
    clear_done  = 1'b0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_din    = 1'b0;
    busy        = (state != IDLE) || clear_pend;
    unique case (state)
      IDLE: begin
        // a late result after a timeout is drained and dropped
        eng_res_ack = eng_res_valid;
        unique case (1'b1)
          do_cfg: begin
            cfg_ready = 1'b1;
            bram_we   = 1'b1;
            bram_addr = cfg_addr;
            bram_din  = cfg_data;
          end
          do_grant: begin
            req_ready = NREQ'(1) << win;
            eng_start = 1'b1;
            eng_tuple = sel;
          end
          default: ;
        endcase
      end
      WAIT_RES: begin
        if (res_now) begin
          eng_res_ack = 1'b1;
          rsp_valid   = NREQ'(1) << owner;
          rsp_hit     = eng_res;
        end else if (tmo_now) begin
          rsp_valid = NREQ'(1) << owner;
          rsp_err   = 1'b1;
        end
      end
      CLEAR: begin
        bram_we    = 1'b1;
        bram_addr  = clr_addr;
        clear_done = clr_last;
      end
      default: ;
    endcase
  end

  // datapath registers: arbitration, ownership, timer, clear walk
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      owner      <= '0;
      timer      <= '0;
      clr_addr   <= '0;
      clear_pend <= 1'b0;
      tuple_q    <= '0;
    end else begin
      if (clear_start)  clear_pend <= 1'b1;
      else if (do_clr)  clear_pend <= 1'b0;
      if (do_clr)              clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (do_grant) begin
        owner   <= win;
        timer   <= '0;
        rr_ptr  <= win_nxt;
        tuple_q <= sel;
      end else if (state == WAIT_RES) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bloom_lookup_sched.sv
// Bench for bloom_lookup_sched: vector table for IDLE decisions,
// hand sequences for clear, timeout and reset; responses via scoreboard.
module tb_bloom_lookup_sched;

  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int TMO  = 64;
  localparam logic [103:0] T0 = 104'hDEAD_BEEF_0123_4567_89AB_CDEF_0;
  localparam logic [103:0] T1 = 104'h1234_5678_9ABC_DEF0_1357_9BDF_2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*104-1:0] req_tuple;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_hit;
  logic              rsp_err;
  logic              eng_ready;
  logic              eng_start;
  logic [103:0]      eng_tuple;
  logic              eng_res_valid;
  logic              eng_res;
  logic              eng_res_ack;
  logic              cfg_valid;
  logic [AW-1:0]     cfg_addr;
  logic              cfg_data;
  logic              cfg_ready;
  logic              clear_start;
  logic              clear_done;
  logic              bram_we;
  logic [AW-1:0]     bram_addr;
  logic              bram_din;
  logic              busy;

  bloom_lookup_sched #(
    .NREQ(NREQ), .ADDR_W(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tuple(req_tuple),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .eng_ready(eng_ready), .eng_start(eng_start),
    .eng_tuple(eng_tuple), .eng_res_valid(eng_res_valid),
    .eng_res(eng_res), .eng_res_ack(eng_res_ack),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .clear_start(clear_start), .clear_done(clear_done),
    .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   idx;
    logic hit;
    logic err;
    int   cyc;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [1:0] rv;
    logic       cv;
    logic [2:0] ca;
    logic       cd;
    logic       er;
    logic [1:0] e_rr;
    logic       e_cr;
    logic       e_we;
    logic [2:0] e_a;
    logic       e_d;
    logic       hit;
  } vec_t;
  vec_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp_v, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  function automatic logic [103:0] tup(input int i);
    return (i == 0) ? T0 : T1;
  endfunction

  // response monitor: every strobe must match the head of the queue
  always @(negedge clk) begin
    if (|rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %b want none", rsp_valid);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("rsp_valid", rsp_valid, 2'b01 << e.idx);
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_grant(input int idx);
    samp;
    chk("req_ready", req_ready, 2'b01 << idx);
    chk("eng_start", eng_start, 1'b1);
    chk("eng_tuple", eng_tuple, tup(idx));
    chk("grant_no_we", bram_we, 1'b0);
  endtask

  // called in the grant cycle; result returned `dly` cycles later
  task automatic finish(input int idx, input logic hit,
                        input int dly, input bit drop);
    sbq.push_back('{idx, hit, 1'b0, cyc + dly});
    step;
    if (drop) begin
      req_valid = '0;
      cfg_valid = 1'b0;
    end
    for (int k = 1; k < dly; k++) begin
      samp;
      chk("hold_start", eng_start, 1'b0);
      chk("hold_tuple", eng_tuple, tup(idx));
      chk("wait_cfg_rdy", cfg_ready, 1'b0);
      step;
    end
    eng_res_valid = 1'b1;
    eng_res = hit;
    samp;
    chk("res_ack", eng_res_ack, 1'b1);
    step;
    eng_res_valid = 1'b0;
    eng_res = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    samp;
    chk({nm, "_rr"}, req_ready, 2'b00);
    chk({nm, "_we"}, bram_we, 1'b0);
    chk({nm, "_addr"}, bram_addr, 3'd0);
    chk({nm, "_done"}, clear_done, 1'b0);
    chk({nm, "_start"}, eng_start, 1'b0);
    chk({nm, "_ack"}, eng_res_ack, 1'b0);
    chk({nm, "_cfgr"}, cfg_ready, 1'b0);
    chk({nm, "_tuple"}, eng_tuple, 104'd0);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tbl[0] = '{2'b00, 0, 3'd0, 0, 1, 2'b00, 0, 0, 3'd0, 0, 0};
    tbl[1] = '{2'b11, 0, 3'd0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 0};
    tbl[2] = '{2'b10, 0, 3'd0, 0, 1, 2'b10, 0, 0, 3'd0, 0, 1};
    tbl[3] = '{2'b11, 0, 3'd0, 0, 1, 2'b01, 0, 0, 3'd0, 0, 0};
    tbl[4] = '{2'b01, 0, 3'd0, 0, 1, 2'b01, 0, 0, 3'd0, 0, 1};
    tbl[5] = '{2'b11, 1, 3'd5, 1, 1, 2'b00, 1, 1, 3'd5, 1, 0};
    tbl[6] = '{2'b00, 1, 3'd2, 0, 1, 2'b00, 1, 1, 3'd2, 0, 0};
    tbl[7] = '{2'b11, 0, 3'd0, 0, 1, 2'b10, 0, 0, 3'd0, 0, 0};

    reset = 1'b1;
    req_valid = '0;
    req_tuple = {T1, T0};
    eng_ready = 1'b1;
    eng_res_valid = 1'b0;
    eng_res = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = 1'b0;
    clear_start = 1'b0;
    repeat (3) step;
    reset = 1'b0;
    chk_quiet("reset");
    chk("reset_rsp", rsp_valid, 2'b00);
    step;

    // IDLE decision table
    foreach (tbl[n]) begin
      req_valid = tbl[n].rv;
      cfg_valid = tbl[n].cv;
      cfg_addr  = tbl[n].ca;
      cfg_data  = tbl[n].cd;
      eng_ready = tbl[n].er;
      samp;
      chk("tv_req_ready", req_ready, tbl[n].e_rr);
      chk("tv_eng_start", eng_start, |tbl[n].e_rr);
      chk("tv_cfg_ready", cfg_ready, tbl[n].e_cr);
      chk("tv_bram_we", bram_we, tbl[n].e_we);
      chk("tv_bram_addr", bram_addr, tbl[n].e_a);
      chk("tv_bram_din", bram_din, tbl[n].e_d);
      if (tbl[n].e_rr != 2'b00) begin
        finish(tbl[n].e_rr[1] ? 1 : 0, tbl[n].hit, 2, 1'b1);
      end else begin
        step;
        req_valid = '0;
        cfg_valid = 1'b0;
      end
    end
    eng_ready = 1'b1;

    // round robin with both requesters held
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk_grant(k % 2);
      finish(k % 2, k[0], 1, 1'b0);
    end
    req_valid = 2'b00;

    // single lookup, result five cycles after the grant
    req_valid = 2'b01;
    chk_grant(0);
    finish(0, 1'b1, 5, 1'b1);

    // config and lookup in the same IDLE cycle
    cfg_valid = 1'b1;
    cfg_addr = 3'd5;
    cfg_data = 1'b1;
    req_valid = 2'b10;
    samp;
    chk("col_cfg_ready", cfg_ready, 1'b1);
    chk("col_we", bram_we, 1'b1);
    chk("col_addr", bram_addr, 3'd5);
    chk("col_din", bram_din, 1'b1);
    chk("col_no_grant", req_ready, 2'b00);
    step;
    cfg_valid = 1'b0;
    chk_grant(1);
    finish(1, 1'b0, 2, 1'b1);

    // clear requested while a lookup is in flight
    req_valid = 2'b01;
    chk_grant(0);
    sbq.push_back('{0, 1'b1, 1'b0, cyc + 4});
    step;
    req_valid = 2'b00;
    clear_start = 1'b1;
    samp;
    chk("cl_wait_we", bram_we, 1'b0);
    chk("cl_wait_busy", busy, 1'b1);
    step;
    clear_start = 1'b0;
    repeat (2) begin
      samp;
      chk("cl_wait_we", bram_we, 1'b0);
      step;
    end
    eng_res_valid = 1'b1;
    eng_res = 1'b1;
    samp;
    chk("cl_res_ack", eng_res_ack, 1'b1);
    chk("cl_res_we", bram_we, 1'b0);
    step;
    eng_res_valid = 1'b0;
    eng_res = 1'b0;
    req_valid = 2'b01;
    samp;
    chk("cl_pend_we", bram_we, 1'b0);
    chk("cl_pend_busy", busy, 1'b1);
    chk("cl_pend_grant", req_ready, 2'b00);
    step;
    for (int k = 0; k < 8; k++) begin
      samp;
      chk("cl_we", bram_we, 1'b1);
      chk("cl_addr", bram_addr, k[2:0]);
      chk("cl_din", bram_din, 1'b0);
      chk("cl_done", clear_done, k == 7);
      chk("cl_busy", busy, 1'b1);
      chk("cl_no_grant", req_ready, 2'b00);
      step;
    end
    req_valid = 2'b00;
    samp;
    chk("cl_after_busy", busy, 1'b0);
    chk("cl_after_we", bram_we, 1'b0);
    step;

    // engine never answers
    req_valid = 2'b10;
    chk_grant(1);
    sbq.push_back('{1, 1'b0, 1'b1, cyc + TMO});
    step;
    req_valid = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      samp;
      if (|rsp_valid) seen = 1'b1;
      else step;
    end
    chk("tmo_seen", seen, 1'b1);
    step;
    eng_res_valid = 1'b1;
    eng_res = 1'b1;
    cfg_valid = 1'b1;
    cfg_addr = 3'd6;
    cfg_data = 1'b1;
    samp;
    chk("stray_ack", eng_res_ack, 1'b1);
    chk("stray_rsp", rsp_valid, 2'b00);
    chk("stray_cfg_rdy", cfg_ready, 1'b1);
    chk("stray_addr", bram_addr, 3'd6);
    step;
    eng_res_valid = 1'b0;
    eng_res = 1'b0;
    cfg_valid = 1'b0;

    // reset in the middle of a clear
    clear_start = 1'b1;
    step;
    clear_start = 1'b0;
    samp;
    chk("rc_busy", busy, 1'b1);
    step;
    for (int k = 0; k < 4; k++) begin
      samp;
      chk("rc_addr", bram_addr, k[2:0]);
      if (k < 3) step;
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_quiet("rc");
      step;
    end

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
